// File: rtl/vreg_op_sequencer_if.sv
// Command and register-file/PE control bus of the vector op sequencer.
// master: issues cmd_*/flush, observes controls; slave: the sequencer.
interface vreg_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_vs1;
  logic [4:0] cmd_vs2;
  logic [4:0] cmd_vd;
  logic [1:0] cmd_vsew;
  logic [1:0] cmd_vlmul;
  logic [4:0] cmd_vl;
  logic       cmd_widening;
  logic       cmd_use_vs3;
  logic       flush;
  logic [4:0] vs1_addr;
  logic [4:0] vs2_addr;
  logic [4:0] vd_addr;
  logic [1:0] vsew;
  logic [1:0] vlmul;
  logic       widening_op;
  logic       pe_valid;
  logic       write;
  logic [1:0] elements_to_write;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output cmd_valid, cmd_vs1, cmd_vs2, cmd_vd,
    output cmd_vsew, cmd_vlmul, cmd_vl,
    output cmd_widening, cmd_use_vs3, flush,
    input  cmd_ready, vs1_addr, vs2_addr, vd_addr,
    input  vsew, vlmul, widening_op, pe_valid,
    input  write, elements_to_write, busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_vs1, cmd_vs2, cmd_vd,
    input  cmd_vsew, cmd_vlmul, cmd_vl,
    input  cmd_widening, cmd_use_vs3, flush,
    output cmd_ready, vs1_addr, vs2_addr, vd_addr,
    output vsew, vlmul, widening_op, pe_valid,
    output write, elements_to_write, busy, done, error
  );
endinterface

// File: rtl/vreg_op_sequencer.sv
// Splits one vector instruction into 4-element beats: RF/PE reads,
// delayed write-back. Ports: clk, n_reset, bus (slave modport).
module vreg_op_sequencer #(
  parameter int unsigned PE_LATENCY = 2
) (
  input logic                clk,
  input logic                n_reset,
  vreg_op_sequencer_if.slave bus
);
  localparam int unsigned L = PE_LATENCY;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0] r_sew;
  logic [1:0] r_lmul;
  logic       r_wid;
  logic       r_vs3;
  logic [4:0] r_rem;
  logic [4:0] r_rd_vs1;
  logic [4:0] r_rd_vs2;
  logic [4:0] r_rd_vd;
  logic [4:0] r_hd_vs1;
  logic [4:0] r_hd_vs2;
  logic [4:0] r_hd_vd;
  logic       r_done;
  logic       r_error;

  // write-back pipeline: entry L-1 is the one writing this cycle
  logic [L-1:0] r_pv;
  logic [4:0]   r_pa [L];
  logic [1:0]   r_pc [L];

  logic       w_ready;
  logic       w_accept;
  logic       w_illegal;
  logic       w_vl0;
  logic       w_flush;
  logic       w_pe;
  logic       w_wr;
  logic       w_last;
  logic       w_pend;
  logic       w_done_nx;
  logic       w_err_nx;
  logic [5:0] w_vlmax;
  logic [4:0] w_lm_msk;
  logic [4:0] w_vd_msk;
  logic [4:0] w_src_step;
  logic [4:0] w_dst_step;
  logic [1:0] w_cnt;
  logic [4:0] w_vs1;
  logic [4:0] w_vs2;
  logic [4:0] w_vd;

  always_comb begin
    w_lm_msk = (5'd1 << bus.cmd_vlmul) - 5'd1;
    w_vd_msk = bus.cmd_widening ?
               {w_lm_msk[3:0], 1'b1} : w_lm_msk;
    w_vlmax  = (6'd4 >> bus.cmd_vsew) << bus.cmd_vlmul;
    w_vl0    = bus.cmd_vl == 5'd0;
    w_illegal = (&bus.cmd_vsew)
             || (&bus.cmd_vlmul)
             || (bus.cmd_widening && bus.cmd_vsew == 2'd2)
             || ({1'b0, bus.cmd_vl} > w_vlmax)
             || (bus.cmd_vd == 5'd0)
             || (|(bus.cmd_vs1 & w_lm_msk))
             || (|(bus.cmd_vs2 & w_lm_msk))
             || (|(bus.cmd_vd & w_vd_msk));
  end

  always_comb begin
    w_src_step = 5'd1 << r_sew;
    w_dst_step = 5'd1 << (r_sew + {1'b0, r_wid});
    w_last     = r_rem <= 5'd4;
    w_cnt      = (r_rem >= 5'd4) ? 2'd0 : r_rem[1:0];
    w_pend     = 1'b0;
    for (int i = 0; i < int'(L) - 1; i++) begin
      w_pend = w_pend | r_pv[i];
    end
  end

  assign w_ready  = (r_state == S_IDLE) && !r_done && !r_error;
  assign w_accept = bus.cmd_valid && w_ready && !bus.flush;
  assign w_flush  = bus.flush && (r_state != S_IDLE);
  assign w_wr     = r_pv[L-1];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_done_nx = 1'b0;
    w_err_nx  = 1'b0;
    unique case (1'b1)
      r_state == S_IDLE: begin
        if (w_accept) begin
          w_err_nx  = w_illegal;
          w_done_nx = !w_illegal && w_vl0;
          if (!w_illegal && !w_vl0) begin
            w_next = S_ISSUE;
          end
        end
      end
      r_state == S_ISSUE: begin
        if (r_vs3) begin
          w_next = S_WAIT;
        end else if (w_last) begin
          w_next = S_DRAIN;
        end
      end
      r_state == S_WAIT: begin
        if (w_wr) begin
          w_done_nx = r_rem == 5'd0;
          w_next = (r_rem == 5'd0) ? S_IDLE : S_ISSUE;
        end
      end
      default: begin
        // this cycle's write is the final one
        if (!w_pend) begin
          w_done_nx = 1'b1;
          w_next    = S_IDLE;
        end
      end
    endcase
    if (w_flush) begin
      w_next    = S_IDLE;
      w_done_nx = 1'b0;
    end
  end

  always_comb begin
    w_pe  = r_state == S_ISSUE;
    w_vs1 = w_pe ? r_rd_vs1 : r_hd_vs1;
    w_vs2 = w_pe ? r_rd_vs2 : r_hd_vs2;
    // write-back address overrides the vs3 read address
    w_vd  = w_wr ? r_pa[L-1] :
            w_pe ? r_rd_vd : r_hd_vd;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sew    <= 2'd0;
      r_lmul   <= 2'd0;
      r_wid    <= 1'b0;
      r_vs3    <= 1'b0;
      r_rem    <= 5'd0;
      r_rd_vs1 <= 5'd0;
      r_rd_vs2 <= 5'd0;
      r_rd_vd  <= 5'd0;
      r_hd_vs1 <= 5'd0;
      r_hd_vs2 <= 5'd0;
      r_hd_vd  <= 5'd0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_pv     <= '0;
      for (int i = 0; i < int'(L); i++) begin
        r_pa[i] <= 5'd0;
        r_pc[i] <= 2'd0;
      end
    end else begin
      r_done   <= w_done_nx;
      r_error  <= w_err_nx;
      r_hd_vs1 <= w_vs1;
      r_hd_vs2 <= w_vs2;
      r_hd_vd  <= w_vd;
      if (w_accept) begin
        r_sew    <= bus.cmd_vsew;
        r_lmul   <= bus.cmd_vlmul;
        r_wid    <= bus.cmd_widening;
        r_vs3    <= bus.cmd_use_vs3;
        r_rem    <= bus.cmd_vl;
        r_rd_vs1 <= bus.cmd_vs1;
        r_rd_vs2 <= bus.cmd_vs2;
        r_rd_vd  <= bus.cmd_vd;
      end else if (w_pe) begin
        r_rem    <= w_last ? 5'd0 : r_rem - 5'd4;
        r_rd_vs1 <= r_rd_vs1 + w_src_step;
        r_rd_vs2 <= r_rd_vs2 + w_src_step;
        r_rd_vd  <= r_rd_vd + w_dst_step;
      end
      for (int i = int'(L) - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1] && !w_flush;
        r_pa[i] <= r_pa[i-1];
        r_pc[i] <= r_pc[i-1];
      end
      r_pv[0] <= w_pe && !w_flush;
      r_pa[0] <= r_rd_vd;
      r_pc[0] <= w_cnt;
    end
  end

  assign bus.cmd_ready         = w_ready;
  assign bus.pe_valid          = w_pe;
  assign bus.write             = w_wr;
  assign bus.elements_to_write = w_wr ? r_pc[L-1] : 2'd0;
  assign bus.vs1_addr          = w_vs1;
  assign bus.vs2_addr          = w_vs2;
  assign bus.vd_addr           = w_vd;
  assign bus.vsew              = r_sew;
  assign bus.vlmul             = r_lmul;
  assign bus.widening_op       = r_wid;
  assign bus.busy              = r_state != S_IDLE;
  assign bus.done              = r_done;
  assign bus.error             = r_error;

endmodule
